// File: rtl/accel_reg_master.sv
// rtl/accel_reg_master.sv - Job-level register master: programs accelerator config, polls STATUS, reports result
module accel_reg_master #(
    parameter int REG_ADDR_WIDTH = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [31:0]               cfg_a_addr,
    input  logic [31:0]               cfg_b_addr,
    input  logic [31:0]               cfg_c_addr,
    input  logic [15:0]               cfg_m_dim,
    input  logic [15:0]               cfg_k_dim,
    input  logic [15:0]               cfg_n_dim,
    input  logic [7:0]                cfg_data_type,
    input  logic [15:0]               cfg_stride_a,
    input  logic [15:0]               cfg_stride_b,
    input  logic [15:0]               cfg_stride_c,
    input  logic                      cfg_irq_en,
    input  logic                      abort,
    output logic                      reg_wr_en,
    output logic                      reg_rd_en,
    output logic [REG_ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0]     reg_wr_data,
    input  logic [DATA_WIDTH-1:0]     reg_rd_data,
    input  logic                      reg_rd_valid,
    output logic                      rsp_valid,
    output logic [1:0]                rsp_code,
    output logic [DATA_WIDTH-1:0]     rsp_status
);
    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_POLL_REQ, S_POLL_WAIT, S_ABORT, S_DONE
    } state_t;

    localparam logic [REG_ADDR_WIDTH-1:0] ADDR_CTRL   = REG_ADDR_WIDTH'(8'h00);
    localparam logic [REG_ADDR_WIDTH-1:0] ADDR_STATUS = REG_ADDR_WIDTH'(8'h04);
    localparam logic [REG_ADDR_WIDTH-1:0] ADDR_A      = REG_ADDR_WIDTH'(8'h08);
    localparam logic [15:0]               CNT_LAST    = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0] RSP_OK = 2'b00, RSP_ERR = 2'b01, RSP_TIMEOUT = 2'b10, RSP_ABORT = 2'b11;

    state_t      r_state;
    logic [3:0]  r_idx;
    logic [15:0] r_cnt;
    logic [31:0] r_a, r_b, r_c;
    logic [15:0] r_m, r_k, r_n, r_sa, r_sb, r_sc;
    logic [7:0]  r_dt;
    logic        r_irq;

    logic [3:0]                w_next_idx;
    logic [REG_ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0]     w_wr_data;
    logic                      w_timeout;
    logic                      w_abort_hit;

    assign w_next_idx  = r_idx + 4'd1;
    assign w_timeout   = (r_cnt == CNT_LAST);
    assign w_abort_hit = abort && (r_state == S_WRITE || r_state == S_POLL_REQ || r_state == S_POLL_WAIT);

    // Write sequence index 0 (A) is issued straight from the inputs at acceptance.
    always_comb begin
        w_wr_addr = '0;
        w_wr_data = '0;
        case (w_next_idx)
            4'd0:  begin w_wr_addr = ADDR_A;                  w_wr_data = DATA_WIDTH'(r_a);  end
            4'd1:  begin w_wr_addr = REG_ADDR_WIDTH'(8'h0C); w_wr_data = DATA_WIDTH'(r_b);  end
            4'd2:  begin w_wr_addr = REG_ADDR_WIDTH'(8'h10); w_wr_data = DATA_WIDTH'(r_c);  end
            4'd3:  begin w_wr_addr = REG_ADDR_WIDTH'(8'h14); w_wr_data = DATA_WIDTH'(r_m);  end
            4'd4:  begin w_wr_addr = REG_ADDR_WIDTH'(8'h18); w_wr_data = DATA_WIDTH'(r_k);  end
            4'd5:  begin w_wr_addr = REG_ADDR_WIDTH'(8'h1C); w_wr_data = DATA_WIDTH'(r_n);  end
            4'd6:  begin w_wr_addr = REG_ADDR_WIDTH'(8'h20); w_wr_data = DATA_WIDTH'(r_dt); end
            4'd7:  begin w_wr_addr = REG_ADDR_WIDTH'(8'h24); w_wr_data = DATA_WIDTH'(r_sa); end
            4'd8:  begin w_wr_addr = REG_ADDR_WIDTH'(8'h28); w_wr_data = DATA_WIDTH'(r_sb); end
            4'd9:  begin w_wr_addr = REG_ADDR_WIDTH'(8'h2C); w_wr_data = DATA_WIDTH'(r_sc); end
            4'd10: begin w_wr_addr = ADDR_CTRL; w_wr_data = DATA_WIDTH'({r_irq, 1'b0, 1'b1}); end
            default: begin w_wr_addr = '0; w_wr_data = '0; end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_a <= '0; r_b <= '0; r_c <= '0;
            r_m <= '0; r_k <= '0; r_n <= '0;
            r_sa <= '0; r_sb <= '0; r_sc <= '0;
            r_dt <= '0; r_irq <= 1'b0;
            cmd_ready   <= 1'b1;
            reg_wr_en   <= 1'b0;
            reg_rd_en   <= 1'b0;
            reg_addr    <= '0;
            reg_wr_data <= '0;
            rsp_valid   <= 1'b0;
            rsp_code    <= '0;
            rsp_status  <= '0;
        end else begin
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            rsp_valid <= 1'b0;
            // Abort outranks every same-edge poll decision or timeout.
            if (w_abort_hit) begin
                r_state     <= S_ABORT;
                reg_wr_en   <= 1'b1;
                reg_addr    <= ADDR_CTRL;
                reg_wr_data <= DATA_WIDTH'(2);
            end else begin
                case (r_state)
                    S_IDLE: if (cmd_valid) begin
                        r_a <= cfg_a_addr; r_b <= cfg_b_addr; r_c <= cfg_c_addr;
                        r_m <= cfg_m_dim; r_k <= cfg_k_dim; r_n <= cfg_n_dim;
                        r_sa <= cfg_stride_a; r_sb <= cfg_stride_b; r_sc <= cfg_stride_c;
                        r_dt <= cfg_data_type; r_irq <= cfg_irq_en;
                        r_idx       <= '0;
                        r_state     <= S_WRITE;
                        cmd_ready   <= 1'b0;
                        reg_wr_en   <= 1'b1;
                        reg_addr    <= ADDR_A;
                        reg_wr_data <= DATA_WIDTH'(cfg_a_addr);
                        rsp_code    <= '0;
                        rsp_status  <= '0;
                    end
                    S_WRITE: if (r_idx == 4'd10) begin
                        r_state   <= S_POLL_REQ;
                        r_cnt     <= '0;
                        reg_rd_en <= 1'b1;
                        reg_addr  <= ADDR_STATUS;
                    end else begin
                        r_idx       <= w_next_idx;
                        reg_wr_en   <= 1'b1;
                        reg_addr    <= w_wr_addr;
                        reg_wr_data <= w_wr_data;
                    end
                    S_POLL_REQ: if (w_timeout) begin
                        r_state   <= S_DONE;
                        rsp_valid <= 1'b1;
                        rsp_code  <= RSP_TIMEOUT;
                    end else begin
                        r_cnt   <= r_cnt + 16'd1;
                        r_state <= S_POLL_WAIT;
                    end
                    S_POLL_WAIT: begin
                        if (reg_rd_valid) rsp_status <= reg_rd_data;
                        if (reg_rd_valid && (reg_rd_data[2] || reg_rd_data[1])) begin
                            r_state   <= S_DONE;
                            rsp_valid <= 1'b1;
                            rsp_code  <= reg_rd_data[2] ? RSP_ERR : RSP_OK;
                        end else if (w_timeout) begin
                            r_state   <= S_DONE;
                            rsp_valid <= 1'b1;
                            rsp_code  <= RSP_TIMEOUT;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                            if (reg_rd_valid) begin
                                r_state   <= S_POLL_REQ;
                                reg_rd_en <= 1'b1;
                            end
                        end
                    end
                    S_ABORT: begin
                        r_state   <= S_DONE;
                        rsp_valid <= 1'b1;
                        rsp_code  <= RSP_ABORT;
                    end
                    S_DONE: begin
                        r_state   <= S_IDLE;
                        cmd_ready <= 1'b1;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_accel_reg_master.sv
// tb/tb_accel_reg_master.sv - Self-checking bench for accel_reg_master (table vectors, corner sequences, random jobs)
module tb_accel_reg_master;
    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cfg_a_addr = '0, cfg_b_addr = '0, cfg_c_addr = '0;
    logic [15:0] cfg_m_dim = '0, cfg_k_dim = '0, cfg_n_dim = '0;
    logic [7:0]  cfg_data_type = '0;
    logic [15:0] cfg_stride_a = '0, cfg_stride_b = '0, cfg_stride_c = '0;
    logic        cfg_irq_en = 1'b0;
    logic        abort = 1'b0;
    logic        reg_wr_en, reg_rd_en;
    logic [7:0]  reg_addr;
    logic [31:0] reg_wr_data;
    logic [31:0] reg_rd_data = '0;
    logic        reg_rd_valid = 1'b0;
    logic        rsp_valid;
    logic [1:0]  rsp_code;
    logic [31:0] rsp_status;

    always #5 clk = ~clk;

    accel_reg_master #(.REG_ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cfg_a_addr(cfg_a_addr), .cfg_b_addr(cfg_b_addr), .cfg_c_addr(cfg_c_addr),
        .cfg_m_dim(cfg_m_dim), .cfg_k_dim(cfg_k_dim), .cfg_n_dim(cfg_n_dim),
        .cfg_data_type(cfg_data_type), .cfg_stride_a(cfg_stride_a),
        .cfg_stride_b(cfg_stride_b), .cfg_stride_c(cfg_stride_c), .cfg_irq_en(cfg_irq_en),
        .abort(abort), .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en), .reg_addr(reg_addr),
        .reg_wr_data(reg_wr_data), .reg_rd_data(reg_rd_data), .reg_rd_valid(reg_rd_valid),
        .rsp_valid(rsp_valid), .rsp_code(rsp_code), .rsp_status(rsp_status)
    );

    // One job: config, responder latency, abort/stray cycles, STATUS script, hand-derived result (-1 = none).
    typedef struct packed {
        logic [31:0] a, b, c;
        logic [15:0] m, k, n, sa, sb, sc;
        logic [7:0]  dt;
        logic        irq;
        int          lat, abort_at, stray, done_idx;
        logic [31:0] fill, done_val;
        logic        hold;
        int          exp_code;
        logic [31:0] exp_status;
    } job_t;

    typedef struct packed {
        logic [15:0] cyc;
        logic        rd;
        logic [7:0]  addr;
        logic [31:0] data;
    } ev_t;

    int          n_checks = 0, n_errors = 0;
    ev_t         exp_q[$], obs_q[$];
    int          exp_rsp_cyc, exp_code;
    logic [31:0] exp_stat;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic logic [31:0] stat_of(input job_t j, input int i);
        return (i == j.done_idx) ? j.done_val : j.fill;
    endfunction

    function automatic ev_t wr_ev(input job_t j, input int k);
        ev_t e;
        e.cyc = 16'(k); e.rd = 1'b0; e.addr = 8'h00; e.data = 32'h0;
        case (k)
            1:  begin e.addr = 8'h08; e.data = j.a; end
            2:  begin e.addr = 8'h0C; e.data = j.b; end
            3:  begin e.addr = 8'h10; e.data = j.c; end
            4:  begin e.addr = 8'h14; e.data = {16'h0, j.m}; end
            5:  begin e.addr = 8'h18; e.data = {16'h0, j.k}; end
            6:  begin e.addr = 8'h1C; e.data = {16'h0, j.n}; end
            7:  begin e.addr = 8'h20; e.data = {24'h0, j.dt}; end
            8:  begin e.addr = 8'h24; e.data = {16'h0, j.sa}; end
            9:  begin e.addr = 8'h28; e.data = {16'h0, j.sb}; end
            10: begin e.addr = 8'h2C; e.data = {16'h0, j.sc}; end
            default: begin e.addr = 8'h00; e.data = {29'h0, j.irq, 1'b0, 1'b1}; end
        endcase
        return e;
    endfunction

    // Reference: cycle offsets from acceptance. Writes 1..11, read i at 12+i*(lat+2), its data at 13+lat+i*(lat+2).
    // The job ends at the earliest of abort, first done/error reply, or the last poll cycle 11+TO.
    task automatic model(input job_t j);
        int p, term, kind, v;
        logic [31:0] s;
        ev_t e;
        exp_q.delete();
        p = j.lat + 2;
        term = 11 + TO;
        kind = 2;
        for (int i = 0; 13 + j.lat + i * p <= 11 + TO; i++) begin
            s = stat_of(j, i);
            if (s[2] || s[1]) begin
                term = 13 + j.lat + i * p;
                kind = s[2] ? 1 : 0;
                break;
            end
        end
        if (j.abort_at > 0 && j.abort_at <= term) begin
            term = j.abort_at;
            kind = 3;
        end
        for (int k = 1; k <= 11 && k <= term; k++) exp_q.push_back(wr_ev(j, k));
        exp_stat = 32'h0;
        for (int i = 0; 12 + i * p <= term; i++) begin
            e.cyc = 16'(12 + i * p); e.rd = 1'b1; e.addr = 8'h04; e.data = 32'h0;
            exp_q.push_back(e);
            v = 13 + j.lat + i * p;
            if (v < term || (v == term && kind != 3)) exp_stat = stat_of(j, i);
        end
        if (kind == 3) begin
            e.cyc = 16'(term + 1); e.rd = 1'b0; e.addr = 8'h00; e.data = 32'h2;
            exp_q.push_back(e);
            exp_rsp_cyc = term + 2;
        end else begin
            exp_rsp_cyc = term + 1;
        end
        exp_code = kind;
    endtask

    task automatic drive_cfg(input job_t j);
        cfg_a_addr = j.a; cfg_b_addr = j.b; cfg_c_addr = j.c;
        cfg_m_dim = j.m; cfg_k_dim = j.k; cfg_n_dim = j.n;
        cfg_data_type = j.dt; cfg_stride_a = j.sa; cfg_stride_b = j.sb; cfg_stride_c = j.sc;
        cfg_irq_en = j.irq;
    endtask

    // Called just after a negedge while the DUT is idle; returns one negedge after rsp_valid.
    task automatic run_job(input job_t j, input string tag);
        int pend[$];
        int rd_idx, rsp_c, busy_bad;
        bit done;
        logic [1:0]  code;
        logic [31:0] stat;
        ev_t e;
        model(j);
        obs_q.delete();
        drive_cfg(j);
        cmd_valid = 1'b1;
        chk({tag, "_ready_idle"}, cmd_ready, 1);
        @(posedge clk);
        rd_idx = 0; rsp_c = -1; busy_bad = 0; done = 1'b0; code = '0; stat = '0;
        for (int c = 1; c <= 300 && !done; c++) begin
            @(negedge clk);
            if (!j.hold) cmd_valid = 1'b0;
            abort = 1'b0;
            reg_rd_valid = 1'b0;
            reg_rd_data = $urandom;
            if (cmd_ready) busy_bad++;
            if (reg_wr_en) begin
                e.cyc = 16'(c); e.rd = 1'b0; e.addr = reg_addr; e.data = reg_wr_data;
                obs_q.push_back(e);
            end
            if (reg_rd_en) begin
                e.cyc = 16'(c); e.rd = 1'b1; e.addr = reg_addr; e.data = 32'h0;
                obs_q.push_back(e);
                pend.push_back(c + 1 + j.lat);
            end
            if (rsp_valid) begin
                done = 1'b1; rsp_c = c; code = rsp_code; stat = rsp_status;
            end
            while (pend.size() > 0 && pend[0] < c) void'(pend.pop_front());
            if (pend.size() > 0 && pend[0] == c) begin
                reg_rd_valid = 1'b1;
                reg_rd_data = stat_of(j, rd_idx);
                rd_idx++;
                void'(pend.pop_front());
            end else if (c == j.stray) begin
                reg_rd_valid = 1'b1;
                reg_rd_data = 32'h6;
            end
            if (c == j.abort_at) abort = 1'b1;
        end
        chk({tag, "_rsp_seen"}, done, 1);
        chk({tag, "_busy_ready"}, busy_bad, 0);
        chk({tag, "_ev_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            chk({tag, "_bus_event"}, obs_q[i], exp_q[i]);
        chk({tag, "_rsp_cycle"}, rsp_c, exp_rsp_cyc);
        chk({tag, "_rsp_code"}, code, exp_code);
        chk({tag, "_rsp_status"}, stat, exp_stat);
        if (j.exp_code >= 0) begin
            chk({tag, "_tab_code"}, code, j.exp_code);
            chk({tag, "_tab_status"}, stat, j.exp_status);
        end
        @(negedge clk);
        abort = 1'b0;
        reg_rd_valid = 1'b0;
        chk({tag, "_pulse_low"}, rsp_valid, 0);
        chk({tag, "_ready_back"}, cmd_ready, 1);
        chk({tag, "_code_hold"}, rsp_code, exp_code);
        chk({tag, "_status_hold"}, rsp_status, exp_stat);
    endtask

    initial begin
        job_t base, j;
        job_t tab[$];
        int bad;

        base = '0;
        base.a = 32'h1000; base.b = 32'h2000; base.c = 32'h3000;
        base.m = 16'd4; base.k = 16'd4; base.n = 16'd4;
        base.dt = 8'h01; base.sa = 16'd16; base.sb = 16'd16; base.sc = 16'd16;
        base.irq = 1'b1; base.done_idx = -1; base.exp_code = -1;

        j = base; j.fill = 32'h1; j.done_idx = 2; j.done_val = 32'h2; j.exp_code = 0; j.exp_status = 32'h2; tab.push_back(j);
        j = base; j.done_idx = 0; j.done_val = 32'h6; j.exp_code = 1; j.exp_status = 32'h6; tab.push_back(j);
        j = base; j.irq = 1'b0; j.lat = 3; j.fill = 32'hFFFF_FFF9; j.done_idx = 1; j.done_val = 32'h4;
        j.exp_code = 1; j.exp_status = 32'h4; tab.push_back(j);
        j = base; j.lat = 1; j.fill = 32'h1; j.exp_code = 2; j.exp_status = 32'h1; tab.push_back(j);
        j = base; j.fill = 32'h1; j.done_idx = 0; j.done_val = 32'h2; j.abort_at = 5; j.stray = 3;
        j.exp_code = 3; j.exp_status = 32'h0; tab.push_back(j);
        j = base; j.fill = 32'h1; j.done_idx = 5; j.done_val = 32'h2; j.abort_at = 14;
        j.exp_code = 3; j.exp_status = 32'h1; tab.push_back(j);
        j = base; j.fill = 32'h1; j.done_idx = 31; j.done_val = 32'h2; j.exp_code = 0; j.exp_status = 32'h2; tab.push_back(j);
        j = base; j.fill = 32'h1; j.done_idx = 32; j.done_val = 32'h2; j.exp_code = 2; j.exp_status = 32'h1; tab.push_back(j);
        j = base; j.fill = 32'h1; j.abort_at = 75; j.exp_code = 3; j.exp_status = 32'h1; tab.push_back(j);
        j = base; j.fill = 32'h1; j.done_idx = 0; j.done_val = 32'h2; j.hold = 1'b1;
        j.exp_code = 0; j.exp_status = 32'h2; tab.push_back(j);
        j = base; j.a = 32'hA000; j.fill = 32'h0; j.done_idx = 1; j.done_val = 32'h2;
        j.exp_code = 0; j.exp_status = 32'h2; tab.push_back(j);

        repeat (2) @(negedge clk);
        chk("reset_outputs", {cmd_ready, reg_wr_en, reg_rd_en, rsp_valid, reg_addr, reg_wr_data, rsp_code}, {1'b1, 3'b000, 8'h0, 32'h0, 2'b00});
        chk("reset_status", rsp_status, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int t = 0; t < tab.size(); t++) run_job(tab[t], $sformatf("tab%0d", t));

        for (int r = 0; r < 30; r++) begin
            j = '0;
            j.a = $urandom; j.b = $urandom; j.c = $urandom;
            j.m = 16'($urandom); j.k = 16'($urandom); j.n = 16'($urandom);
            j.dt = 8'($urandom); j.sa = 16'($urandom); j.sb = 16'($urandom); j.sc = 16'($urandom);
            j.irq = 1'($urandom);
            j.lat = $urandom_range(0, 3);
            j.abort_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 80) : 0;
            j.stray = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 10) : 0;
            j.done_idx = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 5);
            j.fill = $urandom & ~32'h6;
            j.done_val = $urandom | (($urandom_range(0, 1) == 1) ? 32'h2 : 32'h4);
            j.hold = ($urandom_range(0, 3) == 0);
            j.exp_code = -1;
            run_job(j, $sformatf("rnd%0d", r));
        end
        cmd_valid = 1'b0;
        @(negedge clk);

        // Reset in the middle of the configuration writes.
        drive_cfg(base);
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("midwrite_busy", {reg_wr_en, cmd_ready}, 2'b10);
        #2 rst_n = 1'b0;
        #1;
        chk("midwrite_reset_outputs", {cmd_ready, reg_wr_en, reg_rd_en, rsp_valid, reg_addr, reg_wr_data, rsp_code}, {1'b1, 3'b000, 8'h0, 32'h0, 2'b00});
        chk("midwrite_reset_status", rsp_status, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (reg_wr_en || reg_rd_en || rsp_valid || !cmd_ready) bad++;
        end
        chk("post_reset_quiet", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/accel_reg_master.md
ACCEL_REG_MASTER -- requirements
Module: accel_reg_master

Interface
REQ-001 SHALL have parameters: REG_ADDR_WIDTH, default 8, register address width; DATA_WIDTH, default 32, register data width; TIMEOUT_CYCLES, default 4096, poll-phase cycle limit.
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  job request
- cmd_ready  out  1  job accepted when cmd_valid && cmd_ready
- cfg_a_addr, cfg_b_addr, cfg_c_addr  in  32 each  matrix base addresses
- cfg_m_dim, cfg_k_dim, cfg_n_dim  in  16 each  dimensions
- cfg_data_type  in  8  element type
- cfg_stride_a, cfg_stride_b, cfg_stride_c  in  16 each  strides
- cfg_irq_en  in  1  irq enable written to CTRL bit 2
- abort  in  1  cancel current job
- reg_wr_en, reg_rd_en  out  1  register-bus write/read strobes
- reg_addr  out  REG_ADDR_WIDTH  register address
- reg_wr_data  out  DATA_WIDTH  write data
- reg_rd_data  in  DATA_WIDTH  read data
- reg_rd_valid  in  1  read data valid, one cycle
- rsp_valid  out  1  job complete pulse
- rsp_code  out  2  00 ok, 01 accel error, 10 timeout, 11 aborted
- rsp_status  out  DATA_WIDTH  last STATUS word read (0 if none)
REQ-003 Clock: one clock; reset is asynchronous and active-low.

Function
REQ-004 SHALL implement states IDLE, WRITE, POLL_REQ, POLL_WAIT, ABORT, DONE; all bus and response outputs registered.
REQ-005 cmd_ready SHALL be 1 only in IDLE; on acceptance all cfg_* and cfg_irq_en SHALL be latched; state -> WRITE.
REQ-006 WRITE SHALL issue 11 single-cycle writes on consecutive cycles (reg_wr_en=1, reg_rd_en=0), in this order: 0x08 A, 0x0C B, 0x10 C, 0x14 M, 0x18 K, 0x1C N, 0x20 data_type, 0x24 stride_a, 0x28 stride_b, 0x2C stride_c, 0x00 CTRL.
REQ-007 16-bit and 8-bit fields SHALL be zero-extended to DATA_WIDTH; the CTRL write data SHALL be {29'b0, irq_en, 1'b0, 1'b1}.
REQ-008 Timing: acceptance at edge T, writes on cycles T+1..T+11, first STATUS read (reg_rd_en=1, reg_addr=0x04) on cycle T+12.
REQ-009 POLL_REQ SHALL assert reg_rd_en for exactly one cycle, then enter POLL_WAIT; reg_rd_en=0 in POLL_WAIT.
REQ-010 On reg_rd_valid in POLL_WAIT, SHALL capture reg_rd_data into rsp_status and decide:
- bit 2 (error) set -> DONE, code 01; error takes priority over bit 1
- else bit 1 (done) set -> DONE, code 00
- else -> POLL_REQ; next read is on the cycle after reg_rd_valid
REQ-011 A 16-bit cycle counter SHALL clear on entry to the first POLL_REQ and count every POLL_REQ/POLL_WAIT cycle; on reaching TIMEOUT_CYCLES with no decision -> DONE, code 10. A simultaneous reg_rd_valid decision SHALL win over timeout.
REQ-012 abort high at an edge in WRITE/POLL_REQ/POLL_WAIT SHALL cause the next cycle to be one ABORT write: 0x00, data 0x00000002; then DONE, code 11. Remaining config writes SHALL be dropped.
REQ-013 abort SHALL be ignored in IDLE, ABORT and DONE, and SHALL take priority over any same-edge poll decision or timeout.
REQ-014 reg_rd_valid arriving outside POLL_WAIT SHALL be ignored.
REQ-015 DONE SHALL assert rsp_valid for exactly one cycle with rsp_code/rsp_status stable, then enter IDLE; rsp_code and rsp_status SHALL hold until the next acceptance.
REQ-016 A new job SHALL NOT be accepted before the cycle after rsp_valid; cmd_valid held high is accepted then.

Reset
REQ-017 While rst_n=0: state IDLE; cmd_ready=1; reg_wr_en, reg_rd_en, rsp_valid=0; reg_addr, reg_wr_data, rsp_code, rsp_status, counters=0. Reset mid-job SHALL abandon the job with no further bus activity.

Verification
REQ-018 Reset: assert rst_n=0 mid-WRITE -> all outputs 0 immediately, cmd_ready=1.
REQ-019 Normal job: A=0x1000, B=0x2000, C=0x3000, M=K=N=4, irq_en=1, STATUS reads 0x1, 0x1, 0x2 -> 11 writes in REQ-006 order, CTRL data 0x5, 3 reads, rsp_code=00, rsp_status=0x2.
REQ-020 Error: STATUS read 0x6 -> rsp_code=01, rsp_status=0x6.
REQ-021 Timeout: TIMEOUT_CYCLES=64, STATUS always 0x1 -> rsp_valid after 64 poll cycles, rsp_code=10.
REQ-022 Abort during 5th write -> next cycle write 0x00/0x2, no further writes or reads, rsp_code=11.
REQ-023 cmd_valid held high across two jobs -> second acceptance exactly one cycle after first rsp_valid.
